nv_byte_feeder: RTL

//  Upstream stage of the byte Serializer. Buffers command/data bytes written by the NV

---
 rtl/nv_ctrl_pkg.sv | 16 +
 rtl/nv_sync_fifo.sv | 63 ++++++
 rtl/nv_byte_feeder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/nv_ctrl_pkg.sv
// Shared types and constants for the NV byte feeder: default byte width,
// transfer FSM states and the completed-transfer counter width.
package nv_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ARM,
    ST_WAIT,
    ST_GAP
  } state_t;

endpackage

// File: rtl/nv_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level; rd_data shows the head
// entry combinationally so a pop and its data arrive in the same cycle.
module nv_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level_nxt;
  logic              push;
  logic              pop;

  // A write into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + 1'b1;
    end else if (pop && !push) begin
      level_nxt = level - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/nv_byte_feeder.sv
// Buffers controller bytes and feeds them one at a time to the Serializer over
// start/done, with an idle gap after each byte, a transfer counter and sticky errors.
module nv_byte_feeder
  import nv_ctrl_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int DEPTH          = 16,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DATA_W-1:0]        ser_data,
  output logic                     ser_start,
  input  logic                     ser_done,
  output logic                     busy,
  output logic [CNT_W-1:0]         bytes_sent,
  output logic                     err_overflow,
  output logic                     err_timeout,
  input  logic                     clr_err
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int TW      = $clog2(CNT_MAX + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam state_t        POST_XFER = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  state_t            state;
  logic [TW-1:0]     cnt;
  logic              pop;
  logic [DATA_W-1:0] fifo_dat;

  assign pop  = (state == ST_IDLE) && !empty;
  assign busy = (state != ST_IDLE) || !empty;

  nv_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .rd_en   (pop),
    .rd_data (fifo_dat),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      ser_data     <= '0;
      ser_start    <= 1'b0;
      bytes_sent   <= '0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      // Clear first so a same-cycle error event below overrides it.
      if (clr_err) begin
        err_overflow <= 1'b0;
        err_timeout  <= 1'b0;
      end
      if (wr_en && full) err_overflow <= 1'b1;

      ser_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            ser_data  <= fifo_dat;
            ser_start <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          cnt   <= '0;
          state <= ST_ARM;
        end
        ST_ARM: begin
          // Wait for the previous byte's done level to fall before looking for a new one.
          if (cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            cnt         <= '0;
            state       <= POST_XFER;
          end else begin
            cnt <= cnt + 1'b1;
            if (!ser_done) state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ser_done) begin
            bytes_sent <= bytes_sent + 1'b1;
            cnt        <= '0;
            state      <= POST_XFER;
          end else if (cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            cnt         <= '0;
            state       <= POST_XFER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
